// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and defaults for the loader write queue
package loader_pkg;

    localparam int LOADER_ADDR_W = 25;

    typedef struct packed {
        logic [LOADER_ADDR_W-1:0] addr;
        logic [7:0]               data;
    } loader_entry_t;

endpackage

// File: rtl/loader_write_queue_if.sv
// rtl/loader_write_queue_if.sv - download-side and SDRAM-side signals of the loader write queue
interface loader_write_queue_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 25
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              ioctl_download;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              mem_sync;
    logic              loader_we;
    logic [ADDR_W-1:0] loader_addr;
    logic [7:0]        loader_data;
    logic              loader_active;
    logic [LVL_W-1:0]  level;
    logic              overflow;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_sync,
        input  loader_we, loader_addr, loader_data, loader_active, level, overflow
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_sync,
        output loader_we, loader_addr, loader_data, loader_active, level, overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with separate occupancy count; a pop frees room for a same-cycle push
module sync_fifo
    import loader_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = loader_entry_t
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  entry_t                     din,
    output entry_t                     dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // Head leaving this cycle makes room even when full.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/loader_write_queue.sv
// rtl/loader_write_queue.sv - queues download bytes and releases one SDRAM write per mem_sync slot
module loader_write_queue
    import loader_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = LOADER_ADDR_W
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    loader_write_queue_if.slave  bus
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } entry_t;

    entry_t             fifo_din;
    entry_t             fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [$clog2(DEPTH):0] fifo_level;

    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [7:0]         data_q;
    logic               overflow_q;
    logic               active_q;
    logic               download_q;
    logic               drop;

    assign fifo_din = {bus.ioctl_addr, bus.ioctl_dout};
    // A full FIFO is never empty, so a concurrent mem_sync always frees a slot.
    assign drop     = bus.ioctl_wr & fifo_full & ~bus.mem_sync;

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (bus.ioctl_wr),
        .pop     (bus.mem_sync),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            active_q   <= 1'b0;
            download_q <= 1'b0;
        end else begin
            if (bus.mem_sync) begin
                we_q <= ~fifo_empty;
                if (!fifo_empty) begin
                    addr_q <= fifo_dout.addr;
                    data_q <= fifo_dout.data;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.ioctl_download && !download_q) begin
                overflow_q <= 1'b0;
            end
            download_q <= bus.ioctl_download;
            active_q   <= bus.ioctl_download | (fifo_level != '0) | we_q;
        end
    end

    assign bus.loader_we     = we_q;
    assign bus.loader_addr   = addr_q;
    assign bus.loader_data   = data_q;
    assign bus.overflow      = overflow_q;
    assign bus.loader_active = active_q;
    assign bus.level         = fifo_level;

endmodule

// File: tb/tb_loader_write_queue.sv
// tb/tb_loader_write_queue.sv - vector table, directed corner sequences and random traffic against a queue model
module tb_loader_write_queue;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 25;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    loader_write_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    loader_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } ent_t;

    // Reference model: the queue contents plus the slot/flag registers.
    ent_t              mq[$];
    logic              m_we, m_act, m_ovf, m_dl_prev;
    logic [ADDR_W-1:0] m_addr;
    logic [7:0]        m_data;
    ent_t              obs[$];
    int                peak;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit dl, input bit wr,
                              input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit ms);
        int   old_n;
        bit   old_we, popped, dropped;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_we = 0; m_addr = '0; m_data = '0; m_ovf = 0; m_act = 0; m_dl_prev = 0;
            return;
        end
        old_n   = mq.size();
        old_we  = m_we;
        popped  = ms && old_n > 0;
        dropped = 0;
        if (ms) begin
            m_we = popped;
            if (popped) begin
                e = mq.pop_front();
                m_addr = e.a;
                m_data = e.d;
            end
        end
        if (wr) begin
            if (old_n < DEPTH || popped) begin
                e.a = a; e.d = d;
                mq.push_back(e);
            end else begin
                dropped = 1;
            end
        end
        if (dropped) m_ovf = 1;
        else if (dl && !m_dl_prev) m_ovf = 0;
        m_act     = dl || old_n != 0 || old_we;
        m_dl_prev = dl;
    endtask

    task automatic cycle(input bit rst, input bit dl, input bit wr,
                         input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit ms);
        ent_t e;
        @(negedge clk_sys);
        reset              = rst;
        bus.ioctl_download = dl;
        bus.ioctl_wr       = wr;
        bus.ioctl_addr     = a;
        bus.ioctl_dout     = d;
        bus.mem_sync       = ms;
        @(posedge clk_sys);
        model_step(rst, dl, wr, a, d, ms);
        #1;
        chk("model_we",     64'(bus.loader_we),     64'(m_we));
        chk("model_addr",   64'(bus.loader_addr),   64'(m_addr));
        chk("model_data",   64'(bus.loader_data),   64'(m_data));
        chk("model_level",  64'(bus.level),         64'(mq.size()));
        chk("model_ovf",    64'(bus.overflow),      64'(m_ovf));
        chk("model_active", 64'(bus.loader_active), 64'(m_act));
        if (int'(bus.level) > peak) peak = int'(bus.level);
        if (ms && !rst && bus.loader_we) begin
            e.a = bus.loader_addr; e.d = bus.loader_data;
            obs.push_back(e);
        end
    endtask

    typedef struct {
        bit                rst, dl, wr, ms;
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
        bit                e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [7:0]        e_data;
        int                e_level;
        bit                e_ovf, e_act;
    } vec_t;

    vec_t vt[14];

    initial begin
        int found;
        reset = 1'b1;
        bus.ioctl_download = 0; bus.ioctl_wr = 0; bus.ioctl_addr = '0;
        bus.ioctl_dout = '0; bus.mem_sync = 0;

        //        rst dl wr ms  a           d      we addr       data  lvl ovf act
        vt[0]  = '{1, 0, 0, 0, 25'h0,       8'h00, 0, 25'h0,       8'h00, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 25'h0,       8'h00, 0, 25'h0,       8'h00, 0, 0, 1};
        vt[2]  = '{0, 1, 1, 0, 25'h0280000, 8'hA5, 0, 25'h0,       8'h00, 1, 0, 1};
        vt[3]  = '{0, 1, 0, 0, 25'h0,       8'h00, 0, 25'h0,       8'h00, 1, 0, 1};
        vt[4]  = '{0, 1, 0, 0, 25'h0,       8'h00, 0, 25'h0,       8'h00, 1, 0, 1};
        vt[5]  = '{0, 1, 0, 1, 25'h0,       8'h00, 1, 25'h0280000, 8'hA5, 0, 0, 1};
        vt[6]  = '{0, 1, 0, 0, 25'h0,       8'h00, 1, 25'h0280000, 8'hA5, 0, 0, 1};
        vt[7]  = '{0, 0, 0, 0, 25'h0,       8'h00, 1, 25'h0280000, 8'hA5, 0, 0, 1};
        vt[8]  = '{0, 0, 0, 1, 25'h0,       8'h00, 0, 25'h0280000, 8'hA5, 0, 0, 1};
        vt[9]  = '{0, 0, 0, 0, 25'h0,       8'h00, 0, 25'h0280000, 8'hA5, 0, 0, 0};
        vt[10] = '{0, 0, 1, 1, 25'h0000100, 8'h33, 0, 25'h0280000, 8'hA5, 1, 0, 0};
        vt[11] = '{0, 0, 0, 0, 25'h0,       8'h00, 0, 25'h0280000, 8'hA5, 1, 0, 1};
        vt[12] = '{0, 0, 0, 1, 25'h0,       8'h00, 1, 25'h0000100, 8'h33, 0, 0, 1};
        vt[13] = '{0, 0, 0, 1, 25'h0,       8'h00, 0, 25'h0000100, 8'h33, 0, 0, 1};

        for (int i = 0; i < 14; i++) begin
            cycle(vt[i].rst, vt[i].dl, vt[i].wr, vt[i].a, vt[i].d, vt[i].ms);
            chk($sformatf("vec%0d_we", i),     64'(bus.loader_we),     64'(vt[i].e_we));
            chk($sformatf("vec%0d_addr", i),   64'(bus.loader_addr),   64'(vt[i].e_addr));
            chk($sformatf("vec%0d_data", i),   64'(bus.loader_data),   64'(vt[i].e_data));
            chk($sformatf("vec%0d_level", i),  64'(bus.level),         64'(vt[i].e_level));
            chk($sformatf("vec%0d_ovf", i),    64'(bus.overflow),      64'(vt[i].e_ovf));
            chk($sformatf("vec%0d_active", i), 64'(bus.loader_active), 64'(vt[i].e_act));
        end

        // Burst of 8 drained one per 16-cycle slot
        cycle(1, 0, 0, '0, '0, 0);
        obs.delete(); peak = 0;
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 25'h0280000 + 25'(i), 8'h10 + 8'(i), 0);
        for (int s = 0; s < 9; s++) begin
            for (int k = 0; k < 15; k++) cycle(0, 1, 0, '0, '0, 0);
            cycle(0, 1, 0, '0, '0, 1);
        end
        chk("burst_peak", 64'(peak), 64'(8));
        chk("burst_count", 64'(obs.size()), 64'(8));
        for (int i = 0; i < obs.size() && i < 8; i++) begin
            chk("burst_addr", 64'(obs[i].a), 64'(25'h0280000 + 25'(i)));
            chk("burst_data", 64'(obs[i].d), 64'(8'h10 + 8'(i)));
        end
        chk("burst_ovf", 64'(bus.overflow), 64'(0));

        // Overflow: ninth byte dropped, new download clears the flag
        cycle(1, 0, 0, '0, '0, 0);
        obs.delete();
        for (int i = 0; i < 9; i++) cycle(0, 1, 1, 25'h300 + 25'(i), 8'h20 + 8'(i), 0);
        chk("ovf_level", 64'(bus.level), 64'(8));
        chk("ovf_flag", 64'(bus.overflow), 64'(1));
        for (int s = 0; s < 9; s++) begin
            cycle(0, 1, 0, '0, '0, 1);
            cycle(0, 1, 0, '0, '0, 0);
        end
        chk("ovf_drained", 64'(obs.size()), 64'(8));
        found = 0;
        foreach (obs[i]) if (obs[i].d == 8'h28) found++;
        chk("ovf_ninth_absent", 64'(found), 64'(0));
        chk("ovf_sticky", 64'(bus.overflow), 64'(1));
        cycle(0, 0, 0, '0, '0, 0);
        cycle(0, 1, 0, '0, '0, 0);
        chk("ovf_cleared", 64'(bus.overflow), 64'(0));

        // Full FIFO with push and pop in the same cycle
        cycle(1, 0, 0, '0, '0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 25'h400 + 25'(i), 8'h40 + 8'(i), 0);
        cycle(0, 1, 1, 25'h408, 8'h48, 1);
        chk("full_pp_level", 64'(bus.level), 64'(8));
        chk("full_pp_ovf", 64'(bus.overflow), 64'(0));
        chk("full_pp_we", 64'(bus.loader_we), 64'(1));

        // Reset in the middle of a drain
        cycle(1, 0, 0, '0, '0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 25'h500 + 25'(i), 8'h50 + 8'(i), 0);
        cycle(0, 0, 0, '0, '0, 1);
        cycle(1, 0, 0, '0, '0, 0);
        chk("rst_we", 64'(bus.loader_we), 64'(0));
        chk("rst_addr", 64'(bus.loader_addr), 64'(0));
        chk("rst_data", 64'(bus.loader_data), 64'(0));
        chk("rst_level", 64'(bus.level), 64'(0));
        chk("rst_active", 64'(bus.loader_active), 64'(0));
        cycle(0, 0, 0, '0, '0, 1);
        chk("rst_no_write", 64'(bus.loader_we), 64'(0));

        // Random traffic against the model
        begin
            bit dl = 0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 39) == 0) dl = ~dl;
                cycle($urandom_range(0, 249) == 0, dl, $urandom_range(0, 1) == 1,
                      25'($urandom), 8'($urandom), $urandom_range(0, 4) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
